// File: rtl/demux8_dist.sv
// demux8_dist: one DATA_W-bit valid/ready stream scattered to eight one-entry lane registers.
// The lane comes from an explicit select (clamped to 7) or from an internal round-robin pointer.
module demux8_dist #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [3:0]          in_sel,
    input  logic                mode,
    input  logic                rr_clear,
    output logic [7:0]          out_valid,
    input  logic [7:0]          out_ready,
    output logic [8*DATA_W-1:0] out_data,
    output logic [2:0]          rr_ptr,
    output logic [15:0]         word_cnt
);
    localparam int LANES = 8;

    logic [LANES-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [LANES];
    logic [2:0]        rr_q, rr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        tgt;
    logic              accept;

    // Selects 8..15 all map to lane 7.
    assign tgt      = mode ? rr_q : (in_sel[3] ? 3'd7 : in_sel[2:0]);
    assign in_ready = !rst && (!valid_q[tgt] || out_ready[tgt]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no latch is inferred.
        valid_d = valid_q & ~out_ready;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d[tgt] = 1'b1;
            cnt_d        = cnt_q + 16'd1;
            if (mode) begin
                rr_d = rr_q + 3'd1;
            end
        end
        if (rr_clear) begin
            rr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            // NOTE: lane data is reset too, since out_data must read zero after reset.
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            valid_q <= valid_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                data_q[tgt] <= in_data;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign out_data[DATA_W*k +: DATA_W] = data_q[k];
    end

    assign out_valid = valid_q;
    assign rr_ptr    = rr_q;
    assign word_cnt  = cnt_q;
endmodule

// File: tb/tb_demux8_dist.sv
// Directed self-checking bench for demux8_dist: addressed stall, round-robin,
// select clamp, rr_clear priority, mid-stream reset and word counter wrap.
module tb_demux8_dist;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [3:0]   in_sel;
    logic         mode;
    logic         rr_clear;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [511:0] out_data;
    logic [2:0]   rr_ptr;
    logic [15:0]  word_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    demux8_dist #(.DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .mode(mode), .rr_clear(rr_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rr_ptr(rr_ptr), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lane(input int k);
        return out_data[k*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rr_clear = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0;
        mode = 1'b0; rr_clear = 1'b0; out_ready = '0;
        tick();
        tests_run++;
        if (out_valid !== 8'h00 || out_data !== '0 || rr_ptr !== 3'd0 || word_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%h rr=%0d cnt=%0d data_zero=%0b, want 00/0/0/1",
                     out_valid, rr_ptr, word_cnt, out_data == '0);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_addressed_stall();
        mode = 1'b0; in_sel = 4'd3; out_ready = 8'h00;
        in_valid = 1'b1; in_data = 64'hA5A5_0000_0000_0003;
        tick();
        tests_run++;
        if (out_valid !== 8'h08 || lane(3) !== 64'hA5A5_0000_0000_0003 || word_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL addr_first: valid=%h lane3=%h cnt=%0d want 08/a5a5000000000003/1",
                     out_valid, lane(3), word_cnt);
        end
        in_data = 64'hA5A5_0000_0000_0004;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL addr_stall_ready: got %b want 0", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 8'h08 || lane(3) !== 64'hA5A5_0000_0000_0003 || word_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL addr_stall_hold: valid=%h lane3=%h cnt=%0d want 08/a5a5000000000003/1",
                     out_valid, lane(3), word_cnt);
        end
        out_ready = 8'h08;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL addr_passthru_ready: got %b want 1", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 8'h08 || lane(3) !== 64'hA5A5_0000_0000_0004 || word_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL addr_replace: valid=%h lane3=%h cnt=%0d want 08/a5a5000000000004/2",
                     out_valid, lane(3), word_cnt);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 8'h00 || lane(3) !== 64'hA5A5_0000_0000_0004) begin
            tests_failed++;
            $display("FAIL addr_drain: valid=%h lane3=%h want 00/a5a5000000000004", out_valid, lane(3));
        end
        out_ready = 8'h00;
    endtask

    task automatic test_round_robin();
        apply_reset();
        mode = 1'b1; out_ready = 8'hFF; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 64'hD000_0000_0000_0000 | 64'(i);
            tick();
            tests_run++;
            if (out_valid !== (8'h01 << (i % 8)) || lane(i % 8) !== (64'hD000_0000_0000_0000 | 64'(i))) begin
                tests_failed++;
                $display("FAIL rr_word%0d: valid=%h lane%0d=%h want %h/%h", i, out_valid, i % 8,
                         lane(i % 8), 8'h01 << (i % 8), 64'hD000_0000_0000_0000 | 64'(i));
            end
        end
        tests_run++;
        if (rr_ptr !== 3'd2 || word_cnt !== 16'd10) begin
            tests_failed++;
            $display("FAIL rr_final: rr=%0d cnt=%0d want 2/10", rr_ptr, word_cnt);
        end
        in_valid = 1'b0;
        mode = 1'b0;
        tick();
        tests_run++;
        if (rr_ptr !== 3'd2 || out_valid !== 8'h00) begin
            tests_failed++;
            $display("FAIL rr_hold_mode0: rr=%0d valid=%h want 2/00", rr_ptr, out_valid);
        end
    endtask

    task automatic test_sel_clamp();
        mode = 1'b0; out_ready = 8'h00; in_valid = 1'b1;
        in_sel = 4'd2; in_data = 64'h22;
        tick();
        in_sel = 4'd12; in_data = 64'h1234;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 8'h84 || lane(7) !== 64'h1234 || lane(2) !== 64'h22) begin
            tests_failed++;
            $display("FAIL sel_clamp: valid=%h lane7=%h lane2=%h want 84/1234/22",
                     out_valid, lane(7), lane(2));
        end
    endtask

    task automatic test_rr_clear();
        apply_reset();
        mode = 1'b1; out_ready = 8'hFF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 64'(i);
            tick();
        end
        tests_run++;
        if (rr_ptr !== 3'd5) begin
            tests_failed++;
            $display("FAIL rr_setup: rr=%0d want 5", rr_ptr);
        end
        rr_clear = 1'b1; in_data = 64'h55;
        tick();
        rr_clear = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 8'h20 || lane(5) !== 64'h55 || rr_ptr !== 3'd0 || word_cnt !== 16'd6) begin
            tests_failed++;
            $display("FAIL rr_clear: valid=%h lane5=%h rr=%0d cnt=%0d want 20/55/0/6",
                     out_valid, lane(5), rr_ptr, word_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mode = 1'b1; out_ready = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 64'hF0 + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 8'hFF || lane(6) !== 64'hF6 || word_cnt !== 16'd8) begin
            tests_failed++;
            $display("FAIL fill_all: valid=%h lane6=%h cnt=%0d want ff/f6/8", out_valid, lane(6), word_cnt);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 8'h00 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%h ready=%b want 00/0", out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 8'h00 || out_data !== '0 || rr_ptr !== 3'd0 || word_cnt !== 16'd0
            || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%h zero=%0b rr=%0d cnt=%0d ready=%b want 00/1/0/0/1",
                     out_valid, out_data == '0, rr_ptr, word_cnt, in_ready);
        end
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        mode = 1'b0; in_sel = 4'd0; out_ready = 8'hFF; in_valid = 1'b1; in_data = 64'h7;
        repeat (65535) tick();
        tests_run++;
        if (word_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL cnt_ffff: got %h want ffff", word_cnt);
        end
        repeat (2) tick();
        in_valid = 1'b0;
        tests_run++;
        if (word_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL cnt_wrap: got %h want 0001", word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_addressed_stall();
        test_round_robin();
        test_sel_clamp();
        test_rr_clear();
        test_reset_mid();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/demux8_dist.md
# demux8_dist

Single-source to eight-lane word distributor for the accelerator datapath. It is the scatter-side counterpart of the 8:1 64-bit word selector: one 64-bit valid/ready input stream is steered to one of eight lanes. Each lane has a one-entry output register with its own valid/ready handshake. The lane is chosen either by an explicit 4-bit lane select or by an internal round-robin pointer, and an accepted-word counter is provided for debug and throughput monitoring.

## Interface
- DATA_W, 64, word width per lane; lane count is fixed at 8.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when high together with in_valid.
- in_data  in  DATA_W  input word.
- in_sel  in  4  target lane in addressed mode. 0..7 select lanes 0..7; 8..15 select lane 7.
- mode  in  1  0 = addressed (in_sel), 1 = round-robin (rr_ptr).
- rr_clear  in  1  synchronous clear of the round-robin pointer to 0.
- out_valid  out  8  per-lane output register full.
- out_ready  in  8  per-lane consumer ready.
- out_data  out  8*DATA_W  lane k occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- rr_ptr  out  3  current round-robin lane.
- word_cnt  out  16  accepted input words, modulo 2^16.

## Operation
- Target lane t = (mode ? rr_ptr : min(in_sel, 7)).
- Lane register k empties on (out_valid[k] & out_ready[k]).
- in_ready = !rst & (!out_valid[t] | out_ready[t]). The path from out_ready to in_ready is combinational; there is no combinational path from in_valid to in_ready.
- Accept = in_valid & in_ready. On accept:
  - lane t loads in_data and sets out_valid[t] = 1;
  - word_cnt increments.
- On a drain without a load, out_valid[k] clears. out_data[k] holds its last value.
- Simultaneous drain and load on the same lane: the new word replaces the old one and out_valid[k] stays 1. No bubble occurs.
- Lanes other than t are unaffected by accept and drain independently.
- rr_ptr advances by 1 on each accept while mode = 1 and wraps from 7 to 0. It holds while mode = 0.
- When rr_clear is asserted:
  - rr_ptr is 0 next cycle, taking priority over the advance;
  - a word accepted in the same cycle still goes to the pre-clear rr_ptr lane.
- A mode change takes effect in the same cycle: t is recomputed combinationally. rr_ptr is not reset by a mode change.
- word_cnt wraps from 0xFFFF to 0x0000. It is cleared only by rst.
- If in_valid is high and in_ready is low, the source must hold in_data, in_sel and mode stable until acceptance.
- If in_valid is low, no state changes except lane drains.

## Timing
- Reset (asynchronous assert, synchronous deassert at clk): out_valid = 0, out_data = 0, rr_ptr = 0, word_cnt = 0, in_ready = 0 while rst is high.
- Latency: a word accepted at edge n is visible on out_valid[t] and out_data[t] after edge n; the consumer may take it at edge n+1.
- Throughput: 1 word/cycle sustained into any lane whose out_ready stays high. Round-robin with all out_ready high delivers lanes 0,1,...,7,0 on consecutive cycles.
- Reset mid-operation: all buffered lane words are discarded and no partial state remains. in_ready rises the first cycle after rst deasserts.

## Test plan
- Reset release, mode = 0, in_sel = 3, data 0xA5A5_0000_0000_0003, out_ready = 0 -> accepted in 1 cycle; out_valid = 8'b0000_1000; next word to lane 3 stalls (in_ready = 0) until out_ready[3] = 1, then accepted the same cycle, with out_valid[3] remaining 1.
- mode = 1, all out_ready = 1, 10 back-to-back words D0..D9 -> lanes 0..7,0,1 receive them in order; rr_ptr = 2; word_cnt = 10.
- in_sel = 12 with data 0x1234 -> lane 7 loads 0x1234; no other out_valid bit changes.
- mode = 1, rr_ptr = 5, rr_clear and accept in the same cycle -> word lands in lane 5; rr_ptr = 0 next cycle.
- Fill lanes 0..7 with out_ready = 0, assert rst mid-stream for 1 cycle -> all out_valid = 0, out_data = 0, rr_ptr = 0, word_cnt = 0, in_ready = 1 the cycle after release.
- 65 537 accepts with all out_ready = 1 -> word_cnt = 1 (wrap verified).
